// File: rtl/photo_save_ctrl_pkg.sv
// Shared definitions for the photo save / gallery paths.
// States, frame geometry and the default SD-card slot layout.
package photo_save_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SEC_REQ,
        ST_SEC_DATA,
        ST_DONE
    } save_state_t;

    localparam int FRAME_W      = 640;
    localparam int FRAME_H      = 480;
    localparam int PIXEL_BITS   = 16;
    localparam int SECTOR_BYTES = 512;

    localparam int DEF_FRAME_SECTORS =
        FRAME_W * FRAME_H * PIXEL_BITS / 8 / SECTOR_BYTES;
    localparam int DEF_WORDS_PER_SECTOR =
        SECTOR_BYTES * 8 / PIXEL_BITS;

    localparam logic [31:0] DEF_BASE_SECTOR  = 32'd8192;
    localparam int          DEF_SLOT_SECTORS = 2048;
    localparam int          DEF_PHOTO_SLOTS  = 4;

endpackage

// File: rtl/photo_save_ctrl_if.sv
// Save-read FIFO port and SD sector-write port of the save path.
// master = photo_save_ctrl, slave = selector / SD controller side.
interface photo_save_ctrl_if;
    logic        save_read_req;
    logic        save_read_req_ack;
    logic        save_read_en;
    logic [15:0] save_read_data;
    logic        sd_sec_write_req;
    logic [31:0] sd_sec_write_addr;
    logic        sd_sec_write_req_ack;
    logic        sd_sec_write_data_req;
    logic [15:0] sd_sec_write_data;
    logic        sd_sec_write_end;

    modport master (
        output save_read_req,
        input  save_read_req_ack,
        output save_read_en,
        input  save_read_data,
        output sd_sec_write_req,
        output sd_sec_write_addr,
        input  sd_sec_write_req_ack,
        input  sd_sec_write_data_req,
        output sd_sec_write_data,
        input  sd_sec_write_end
    );

    modport slave (
        input  save_read_req,
        output save_read_req_ack,
        input  save_read_en,
        output save_read_data,
        input  sd_sec_write_req,
        input  sd_sec_write_addr,
        output sd_sec_write_req_ack,
        output sd_sec_write_data_req,
        input  sd_sec_write_data,
        output sd_sec_write_end
    );
endinterface

// File: rtl/photo_save_ctrl_sector_addr_gen.sv
// Maps (slot, sector within frame) to an absolute SD sector number.
// Shared with the gallery read path.
module sector_addr_gen
    import photo_save_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_SECTOR  = DEF_BASE_SECTOR,
    parameter int          SLOT_SECTORS = DEF_SLOT_SECTORS,
    parameter int          SW           = 2,
    parameter int          CW           = 11
) (
    input  logic [SW-1:0] slot_idx,
    input  logic [CW-1:0] sector_cnt,
    output logic [31:0]   addr
);

    assign addr = BASE_SECTOR
                + 32'(slot_idx) * 32'(SLOT_SECTORS)
                + 32'(sector_cnt);

endmodule

// File: rtl/photo_save_ctrl.sv
// Drains one frame from the save-read FIFO into SD sector writes.
// Optional watchdog: define PHOTO_SAVE_TIMEOUT_EN.
module photo_save_ctrl
    import photo_save_ctrl_pkg::*;
#(
    parameter int          FRAME_SECTORS    = DEF_FRAME_SECTORS,
    parameter int          WORDS_PER_SECTOR = DEF_WORDS_PER_SECTOR,
    parameter logic [31:0] BASE_SECTOR      = DEF_BASE_SECTOR,
    parameter int          SLOT_SECTORS     = DEF_SLOT_SECTORS,
    parameter int          PHOTO_SLOTS      = DEF_PHOTO_SLOTS,
    parameter logic [23:0] TIMEOUT_CYCLES   = 24'd5000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     photo_save,
    photo_save_ctrl_if.master        bus,
    output logic                     saved,
    output logic                     busy,
    output logic [((PHOTO_SLOTS > 1) ? $clog2(PHOTO_SLOTS) : 1)-1:0] slot_idx,
    output logic                     save_err
);

    localparam int SW = (PHOTO_SLOTS > 1) ? $clog2(PHOTO_SLOTS) : 1;
    localparam int CW = $clog2(FRAME_SECTORS + 1);
    localparam int WW = $clog2(WORDS_PER_SECTOR + 1);

    localparam logic [CW-1:0] LAST_SEC  = CW'(FRAME_SECTORS - 1);
    localparam logic [WW-1:0] WPS       = WW'(WORDS_PER_SECTOR);
    localparam logic [SW-1:0] LAST_SLOT = SW'(PHOTO_SLOTS - 1);

    if (SLOT_SECTORS < FRAME_SECTORS || TIMEOUT_CYCLES == 24'd0)
    begin : g_bad_cfg
        $error("photo_save_ctrl: slot stride or watchdog limit invalid");
    end

    save_state_t   state_q, state_d;
    logic [CW-1:0] sec_q, sec_d;
    logic [WW-1:0] word_q, word_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          pop;
    logic [31:0]   sec_addr;

`ifdef PHOTO_SAVE_TIMEOUT_EN
    logic [23:0] wd_q;
    logic        err_q;
    logic        stalled;
    logic        abort;

    assign stalled = (state_q == ST_REQ || state_q == ST_SEC_REQ
                      || state_q == ST_SEC_DATA)
                     && (wd_q >= TIMEOUT_CYCLES - 24'd1);
`endif

    sector_addr_gen #(
        .BASE_SECTOR  (BASE_SECTOR),
        .SLOT_SECTORS (SLOT_SECTORS),
        .SW           (SW),
        .CW           (CW)
    ) u_addr (
        .slot_idx   (slot_q),
        .sector_cnt (sec_q),
        .addr       (sec_addr)
    );

    // State, sector/word counters and slot pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sec_q   <= '0;
            word_q  <= '0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            word_q  <= word_d;
            slot_q  <= slot_d;
        end
    end

    // Next state; pops only while the sector still owes words.
    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        word_d  = word_q;
        slot_d  = slot_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (photo_save) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus.save_read_req_ack) begin
                    sec_d   = '0;
                    state_d = ST_SEC_REQ;
                end
            end
            ST_SEC_REQ: begin
                if (bus.sd_sec_write_req_ack) begin
                    word_d  = '0;
                    state_d = ST_SEC_DATA;
                end
            end
            ST_SEC_DATA: begin
                pop = bus.sd_sec_write_data_req && (word_q < WPS);
                if (pop) word_d = word_q + 1'b1;
                if (bus.sd_sec_write_end) begin
                    sec_d   = sec_q + 1'b1;
                    state_d = (sec_q == LAST_SEC) ? ST_DONE : ST_SEC_REQ;
                end
            end
            ST_DONE: begin
                slot_d  = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef PHOTO_SAVE_TIMEOUT_EN
        abort = stalled && (state_d == state_q) && !pop;
        if (abort) state_d = ST_IDLE;
`endif
    end

`ifdef PHOTO_SAVE_TIMEOUT_EN
    // Watchdog restarts on any progress; a stalled handshake aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_d != state_q || pop) wd_q <= '0;
            else if (busy)                 wd_q <= wd_q + 1'b1;
            if (state_q == ST_IDLE && photo_save) err_q <= 1'b0;
            else if (abort)                       err_q <= 1'b1;
        end
    end

    assign save_err = err_q;
`else
    assign save_err = 1'b0;
`endif

    assign bus.save_read_req     = (state_q == ST_REQ);
    assign bus.sd_sec_write_req  = (state_q == ST_SEC_REQ);
    assign bus.sd_sec_write_addr = (state_q == ST_SEC_REQ) ? sec_addr : '0;
    assign bus.save_read_en      = pop;
    assign bus.sd_sec_write_data = pop ? bus.save_read_data : 16'h0000;
    assign saved                 = (state_q == ST_DONE);
    assign busy                  = (state_q != ST_IDLE);
    assign slot_idx              = slot_q;

endmodule

// File: tb/tb_photo_save_ctrl.sv
// Self-checking bench for photo_save_ctrl.
// Bench acts as selector FIFO and SD controller; model predicts outputs.
module tb_photo_save_ctrl;

    localparam int          FS       = 2;
    localparam int          WPS      = 4;
    localparam int          SLOTS    = 4;
    localparam int          SLOT_SEC = 10;
    localparam logic [31:0] BASE     = 32'd100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       photo_save = 1'b0;
    logic       saved, busy, save_err;
    logic [1:0] slot_idx;

    photo_save_ctrl_if bus ();

    photo_save_ctrl #(
        .FRAME_SECTORS    (FS),
        .WORDS_PER_SECTOR (WPS),
        .BASE_SECTOR      (BASE),
        .SLOT_SECTORS     (SLOT_SEC),
        .PHOTO_SLOTS      (SLOTS),
        .TIMEOUT_CYCLES   (24'd50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .photo_save (photo_save),
        .bus        (bus),
        .saved      (saved),
        .busy       (busy),
        .slot_idx   (slot_idx),
        .save_err   (save_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic        e_req = 0, e_sreq = 0, e_en = 0;
    logic        e_saved = 0, e_busy = 0, e_err = 0;
    logic [31:0] e_addr = 0;
    logic [15:0] e_data = 0;
    int          m_slot = 0;
    logic [15:0] fifo_word = 16'h0001;

    logic [15:0] rx_q[$];
    logic [31:0] addr_q[$];
    int          en_cnt = 0;
    int          saved_cnt = 0;

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        checks++;
        if (bus.save_read_req === e_req && bus.sd_sec_write_req === e_sreq
            && bus.sd_sec_write_addr === e_addr && bus.save_read_en === e_en
            && bus.sd_sec_write_data === e_data && saved === e_saved
            && busy === e_busy && slot_idx === 2'(m_slot)
            && save_err === e_err)
            passes++;
        else
            $display("FAIL cycle t=%0t req=%b/%b sreq=%b/%b addr=%0d/%0d en=%b/%b data=%h/%h saved=%b/%b busy=%b/%b slot=%0d/%0d err=%b/%b",
                     $time, bus.save_read_req, e_req, bus.sd_sec_write_req, e_sreq,
                     bus.sd_sec_write_addr, e_addr, bus.save_read_en, e_en,
                     bus.sd_sec_write_data, e_data, saved, e_saved, busy, e_busy,
                     slot_idx, m_slot, save_err, e_err);
    end

    // Transaction log used by the literal checks.
    always @(negedge clk) begin
        if (bus.sd_sec_write_data_req) rx_q.push_back(bus.sd_sec_write_data);
        if (bus.sd_sec_write_req && bus.sd_sec_write_req_ack)
            addr_q.push_back(bus.sd_sec_write_addr);
        if (bus.save_read_en) en_cnt++;
        if (saved) saved_cnt++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_set(input logic rq, input logic srq, input logic [31:0] ad,
                           input logic en, input logic [15:0] dt,
                           input logic sv, input logic bz);
        e_req = rq; e_sreq = srq; e_addr = ad; e_en = en;
        e_data = dt; e_saved = sv; e_busy = bz;
    endtask

    task automatic do_save(input int ack_dly, input int nreq,
                           input bit rnd, input bit abort_rst);
        int          sack, gap, popped, nr;
        bit          end_same;
        logic [31:0] ad;
        fifo_word = 16'h0001;
        bus.save_read_data = fifo_word;
        photo_save = 1'b1;
        exp_set(0, 0, 0, 0, 0, 0, 0);
        cyc();
        photo_save = 1'b0;
        e_err = 1'b0;
        for (int i = 0; i < ack_dly; i++) begin
            exp_set(1, 0, 0, 0, 0, 0, 1);
            cyc();
        end
        bus.save_read_req_ack = 1'b1;
        exp_set(1, 0, 0, 0, 0, 0, 1);
        cyc();
        bus.save_read_req_ack = 1'b0;
        for (int s = 0; s < FS; s++) begin
            photo_save = 1'b0;
            ad = BASE + 32'(m_slot * SLOT_SEC + s);
            sack = rnd ? int'($urandom_range(0, 3)) : 0;
            for (int i = 0; i < sack; i++) begin
                exp_set(0, 1, ad, 0, 0, 0, 1);
                cyc();
            end
            bus.sd_sec_write_req_ack = 1'b1;
            exp_set(0, 1, ad, 0, 0, 0, 1);
            cyc();
            bus.sd_sec_write_req_ack = 1'b0;
            popped = 0;
            nr = rnd ? int'($urandom_range(2, 6)) : nreq;
            end_same = rnd ? bit'($urandom_range(0, 1)) : 1'b0;
            for (int k = 0; k < nr; k++) begin
                if (abort_rst && k == 2) begin
                    rst_n = 1'b0;
                    photo_save = 1'b0;
                    bus.sd_sec_write_data_req = 1'b0;
                    m_slot = 0;
                    exp_set(0, 0, 0, 0, 0, 0, 0);
                    cyc();
                    cyc();
                    rst_n = 1'b1;
                    cyc();
                    return;
                end
                gap = rnd ? int'($urandom_range(0, 2)) : 0;
                for (int g = 0; g < gap; g++) begin
                    photo_save = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                    exp_set(0, 0, 0, 0, 0, 0, 1);
                    cyc();
                end
                photo_save = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.sd_sec_write_data_req = 1'b1;
                bus.save_read_data = fifo_word;
                bus.sd_sec_write_end = end_same && (k == nr - 1);
                if (popped < WPS) exp_set(0, 0, 0, 1, fifo_word, 0, 1);
                else              exp_set(0, 0, 0, 0, 0, 0, 1);
                cyc();
                if (popped < WPS) begin
                    popped++;
                    fifo_word++;
                    bus.save_read_data = fifo_word;
                end
                bus.sd_sec_write_data_req = 1'b0;
                bus.sd_sec_write_end = 1'b0;
            end
            if (!end_same) begin
                bus.sd_sec_write_end = 1'b1;
                exp_set(0, 0, 0, 0, 0, 0, 1);
                cyc();
                bus.sd_sec_write_end = 1'b0;
            end
        end
        photo_save = 1'b0;
        exp_set(0, 0, 0, 0, 0, 1, 1);
        cyc();
        m_slot = (m_slot + 1) % SLOTS;
        exp_set(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int wrap_exp[3];
        int sv0;
        wrap_exp = '{111, 121, 131};
        bus.save_read_req_ack     = 1'b0;
        bus.save_read_data        = 16'h0000;
        bus.sd_sec_write_req_ack  = 1'b0;
        bus.sd_sec_write_data_req = 1'b0;
        bus.sd_sec_write_end      = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset busy", busy, 0);
        chk("reset slot", slot_idx, 0);

        rx_q.delete(); addr_q.delete(); saved_cnt = 0;
        do_save(3, 4, 0, 0);
        chk("single addr count", addr_q.size(), 2);
        chk("single addr0", addr_q[0], 100);
        chk("single addr1", addr_q[1], 101);
        chk("single word count", rx_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("single data", rx_q[i], i + 1);
        chk("single saved", saved_cnt, 1);
        chk("single slot", slot_idx, 1);

        for (int j = 0; j < 3; j++) begin
            addr_q.delete();
            do_save(1, 4, 0, 0);
            chk("wrap addr", addr_q[1], wrap_exp[j]);
        end
        chk("wrap slot", slot_idx, 0);
        addr_q.delete();
        do_save(0, 4, 0, 0);
        chk("fifth addr", addr_q[0], 100);

        en_cnt = 0; rx_q.delete();
        do_save(2, 6, 0, 0);
        chk("over en count", en_cnt, 8);
        chk("over word count", rx_q.size(), 12);
        chk("over first", rx_q[0], 1);
        chk("over extra a", rx_q[4], 0);
        chk("over extra b", rx_q[5], 0);
        chk("over sec2 first", rx_q[6], 5);
        chk("over extra c", rx_q[11], 0);

        saved_cnt = 0;
        repeat (25) begin
            repeat ($urandom_range(0, 3)) cyc();
            do_save(int'($urandom_range(0, 4)), 0, 1, 0);
        end
        chk("random saved", saved_cnt, 25);

        do_save(1, 4, 0, 1);
        chk("abort busy", busy, 0);
        chk("abort slot", slot_idx, 0);
        addr_q.delete();
        do_save(0, 4, 0, 0);
        chk("after reset addr", addr_q[0], 100);

`ifdef PHOTO_SAVE_TIMEOUT_EN
        sv0 = saved_cnt;
        photo_save = 1'b1;
        exp_set(0, 0, 0, 0, 0, 0, 0);
        cyc();
        photo_save = 1'b0;
        for (int i = 0; i < 50; i++) begin
            exp_set(1, 0, 0, 0, 0, 0, 1);
            cyc();
        end
        exp_set(0, 0, 0, 0, 0, 0, 0);
        e_err = 1'b1;
        cyc();
        chk("timeout err", save_err, 1);
        chk("timeout no saved", saved_cnt, sv0);
        chk("timeout slot", slot_idx, 1);
        do_save(0, 4, 0, 0);
        chk("err cleared", save_err, 0);
`else
        sv0 = 0;
`endif
        cyc();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/photo_save_ctrl.md
Name: photo_save_ctrl

Overview:
Initiator side of the save-read path. On a photo_save pulse it requests a frame read from the SDRAM target selector with save_read_req/save_read_req_ack, then drains the frame word by word into SD-card sector writes. When the frame is written it pulses saved back to key control. Sits between sdram_target_sel (save read port) and the SD-card sector-write controller, clocked by the SD-card clock.

Parameters:
FRAME_SECTORS, 1200, sectors per frame (640x480x16 bit / 512 B)
WORDS_PER_SECTOR, 256, 16-bit words per 512-byte sector
BASE_SECTOR, 32'd8192, first SD sector of photo slot 0
SLOT_SECTORS, 2048, sector stride between photo slots (must be >= FRAME_SECTORS)
PHOTO_SLOTS, 4, number of slots; slot index wraps
TIMEOUT_CYCLES, 24'd5000000, watchdog limit (optional feature only)

Ports:
clk  in  1  SD-card clock
rst_n  in  1  asynchronous active-low reset
photo_save  in  1  one-cycle save command
save_read_req  out  1  frame read request to target selector
save_read_req_ack  in  1  read request accepted
save_read_en  out  1  pop one word from the save read FIFO
save_read_data  in  16  FIFO word, valid in the same cycle as save_read_en (show-ahead FIFO)
sd_sec_write_req  out  1  sector write request
sd_sec_write_addr  out  32  sector address, stable while the request is high
sd_sec_write_req_ack  in  1  sector write accepted
sd_sec_write_data_req  in  1  SD controller wants the next word
sd_sec_write_data  out  16  word to SD controller
sd_sec_write_end  in  1  sector write finished (pulse)
saved  out  1  one-cycle pulse: frame stored
busy  out  1  high in any state except IDLE
slot_idx  out  $clog2(PHOTO_SLOTS)  slot the next or current save targets
save_err  out  1  sticky error flag (optional feature; otherwise tied 0)

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including slot_idx, sector and word counters.
- IDLE: photo_save=1 -> REQ. photo_save in any other state is ignored.
- REQ: save_read_req=1 (registered) until save_read_req_ack=1 is sampled. On the ack it drops next cycle, sector_cnt=0, go to SEC_REQ.
- SEC_REQ: sd_sec_write_req=1, sd_sec_write_addr = BASE_SECTOR + slot_idx*SLOT_SECTORS + sector_cnt, computed in 32 bits. On sd_sec_write_req_ack the request drops, word_cnt=0, go to SEC_DATA.
- SEC_DATA: save_read_en = sd_sec_write_data_req && (word_cnt < WORDS_PER_SECTOR), combinational. sd_sec_write_data = save_read_data, passed straight through. word_cnt increments per pop. data_req beyond WORDS_PER_SECTOR pops nothing and drives 16'h0000.
- SEC_DATA waits for sd_sec_write_end; also accepted the same cycle as the last pop. On it, sector_cnt+1:
  - if sector_cnt+1 == FRAME_SECTORS -> DONE
  - else -> SEC_REQ.
  - end before all words were popped: move on anyway; the remaining FIFO words are left for the selector to flush.
- DONE: saved=1 for exactly one cycle. slot_idx increments, wrapping PHOTO_SLOTS-1 -> 0. Go to IDLE.
- Latency: photo_save to save_read_req is 1 cycle. save_read_req_ack to sd_sec_write_req is 1 cycle. Last sd_sec_write_end to saved is 1 cycle.
- Reset mid-operation: immediate return to IDLE, all requests dropped, slot_idx cleared.

Optional Feature:
- Macro: PHOTO_SAVE_TIMEOUT_EN.
- Defined: a 24-bit watchdog clears on every state change and on every save_read_en. If it reaches TIMEOUT_CYCLES in REQ, SEC_REQ or SEC_DATA:
  - all requests drop and the state goes to IDLE
  - save_err sets and stays set until the next photo_save or reset
  - no saved pulse; slot_idx unchanged.
- Not defined: no watchdog; save_err is constant 0; a missing handshake stalls the block forever.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, REQ, SEC_REQ, SEC_DATA, DONE)
  - frame geometry constants (640, 480, 16 bit, 512-byte sector), shared with the SD read/gallery path
  - default BASE_SECTOR and SLOT_SECTORS.
- One sub-module: sector_addr_gen (slot_idx, sector_cnt -> 32-bit address), so the gallery read path can reuse it.

Test Plan:
- Bench parameters: FRAME_SECTORS=2, WORDS_PER_SECTOR=4, BASE_SECTOR=100, SLOT_SECTORS=10, PHOTO_SLOTS=4.
- Single save: photo_save pulse, ack after 3 cycles, FIFO data 16'h0001..16'h0008 -> sector writes at addr 100 then 101, SD receives 1..8 in order, one saved pulse, slot_idx=1.
- Slot wrap: four back-to-back saves -> second-sector addresses 101, 111, 121, 131; slot_idx returns to 0; a fifth save writes to 100.
- Over-request: SD asserts data_req 6 times in one sector -> exactly 4 save_read_en pulses; extra words read 16'h0000.
- Busy ignore and reset: photo_save during SEC_DATA -> no effect. rst_n low mid-SEC_DATA -> all outputs 0 next edge, slot_idx=0.
- Timeout (PHOTO_SAVE_TIMEOUT_EN, TIMEOUT_CYCLES=50): ack never arrives -> save_req drops at cycle 50, save_err=1, no saved pulse. The next photo_save clears save_err.
